// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the hh:mm:ss limited-counter chain.
// Optional set-mode inactivity abort: define CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter int HOUR_LIMIT = 24,
    parameter int MIN_LIMIT  = 60,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [7:0] sec_carry,
    input  logic [7:0] min_carry,
    input  logic [3:0] mm_t,
    input  logic [3:0] mm_u,
    input  logic [3:0] hh_t,
    input  logic [3:0] hh_u,
    output logic       sec_run,
    output logic       sec_clr,
    output logic [7:0] min_in,
    output logic       min_sel,
    output logic [7:0] hr_in,
    output logic       hr_sel,
    output logic [1:0] set_mode,
    output logic [7:0] shadow_min,
    output logic [7:0] shadow_hr
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } state_t;

    localparam logic [7:0] HL = 8'(HOUR_LIMIT);
    localparam logic [7:0] ML = 8'(MIN_LIMIT);

    state_t     state;
    logic [7:0] cap_hr_raw;
    logic [7:0] cap_min_raw;
    logic [7:0] cap_hr;
    logic [7:0] cap_min;
    logic       editing;
    logic       any_btn;
    logic       timeout;

    function automatic logic [7:0] edit(
        input logic [7:0] v,
        input logic [7:0] lim,
        input logic       inc,
        input logic       dec
    );
        logic [7:0] r;
        r = v;
        if (inc && !dec)
            r = (v == lim - 8'd1) ? 8'd0 : v + 8'd1;
        else if (dec && !inc)
            r = (v == 8'd0) ? lim - 8'd1 : v - 8'd1;
        return r;
    endfunction

    // BCD digits can exceed 9, so range-check the binary value
    assign cap_hr_raw  = {4'd0, hh_t} * 8'd10 + {4'd0, hh_u};
    assign cap_min_raw = {4'd0, mm_t} * 8'd10 + {4'd0, mm_u};
    assign cap_hr      = (cap_hr_raw  >= HL) ? 8'd0 : cap_hr_raw;
    assign cap_min     = (cap_min_raw >= ML) ? 8'd0 : cap_min_raw;

    assign editing = (state == SET_HR) || (state == SET_MIN);
    assign any_btn = mode_btn | inc_btn | dec_btn;

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam logic [7:0] TO = 8'(TIMEOUT_S);
    logic [7:0] to_cnt;

    assign timeout = editing && tick_1hz && !any_btn
                  && (to_cnt == TO - 8'd1);

    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= 8'd0;
        else if (!editing || any_btn)
            to_cnt <= 8'd0;
        else if (tick_1hz)
            to_cnt <= to_cnt + 8'd1;
    end
`else
    // No abort path; the set mode persists until mode_btn or rst
    assign timeout = (TIMEOUT_S < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            shadow_hr  <= 8'd0;
            shadow_min <= 8'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mode_btn) begin
                        state      <= SET_HR;
                        shadow_hr  <= cap_hr;
                        shadow_min <= cap_min;
                    end
                end
                SET_HR: begin
                    if (mode_btn)
                        state <= SET_MIN;
                    else if (timeout)
                        state <= RUN;
                    else
                        shadow_hr <= edit(shadow_hr, HL, inc_btn, dec_btn);
                end
                SET_MIN: begin
                    if (mode_btn)
                        state <= COMMIT;
                    else if (timeout)
                        state <= RUN;
                    else
                        shadow_min <= edit(shadow_min, ML, inc_btn, dec_btn);
                end
                COMMIT: state <= RUN;
            endcase
        end
    end

    // Mux outputs decode the state directly so RUN carries add no latency
    always_comb begin
        sec_run = 1'b0;
        sec_clr = 1'b0;
        min_in  = 8'd0;
        min_sel = 1'b1;
        hr_in   = 8'd0;
        hr_sel  = 1'b1;
        unique case (state)
            RUN: begin
                min_in  = sec_carry;
                hr_in   = min_carry;
                sec_run = tick_1hz;
            end
            SET_HR, SET_MIN: begin
            end
            COMMIT: begin
                min_sel = 1'b0;
                min_in  = shadow_min;
                hr_sel  = 1'b0;
                hr_in   = shadow_hr;
                sec_clr = 1'b1;
            end
        endcase
    end

    assign set_mode = state;

endmodule
